// File: rtl/cherry_mem_pkg.sv
// cherry_mem_pkg: shared widths, sequencer state and tile type for the strided tile dcache path
package cherry_mem_pkg;
  function automatic int aw_f(input int logcnt);
    return 10 + logcnt;
  endfunction
  function automatic int tile_f(input int bits, input int sz);
    return bits * sz * sz;
  endfunction
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} seq_state_t;
  localparam int TILE_W = tile_f(18, 4);
  typedef logic [TILE_W-1:0] tile_t;
endpackage

// File: rtl/dcache_tile_rd_fifo.sv
// dcache_tile_rd_fifo: show-ahead FIFO returning loaded tiles in command order, with occupancy count
module dcache_tile_rd_fifo #(
  parameter int W = 288,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  dat_i,
  input  logic          pop_i,
  output logic [W-1:0]  dat_o,
  output logic [PW:0]   count_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [PW:0] cnt_q;
  logic wr, rd;
  always_comb begin
    rd = pop_i && cnt_q != '0;
    wr = push_i && (cnt_q != (PW+1)'(DEPTH) || rd);
  end
  always_ff @(posedge clk) if (wr) mem_q[wp_q] <= dat_i;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_q + PW'(wr);
      rp_q <= rp_q + PW'(rd);
      cnt_q <= cnt_q + (PW+1)'(wr) - (PW+1)'(rd);
    end
  assign dat_o = mem_q[rp_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/dcache_tile_sequencer.sv
// dcache_tile_sequencer: walks one strided tile load/store command into the dcache, returns loads via a credit FIFO.
// Optional perf counters when DCACHE_TILE_SEQ_PERF_EN is defined.
module dcache_tile_sequencer import cherry_mem_pkg::*; #(
  parameter int SZ = 4,
  parameter int LOGCNT = 5,
  parameter int BITS = 18,
  parameter int CW = 8,
  parameter int MEM_LAT = 2,
  parameter int RD_DEPTH = 4,
  localparam int AW = aw_f(LOGCNT),
  localparam int TILE = tile_f(BITS, SZ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [AW-2:0]   cmd_stride_x,
  input  logic [AW-2:0]   cmd_stride_y,
  input  logic [AW-1:0]   cmd_step,
  input  logic [CW-1:0]   cmd_count,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [TILE-1:0] wr_data,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [TILE-1:0] rd_data,
  output logic            done,
`ifdef DCACHE_TILE_SEQ_PERF_EN
  output logic [31:0]     perf_stall_cycles,
  output logic [31:0]     perf_tiles,
`endif
  output logic [AW-1:0]   mem_addr,
  output logic [AW-2:0]   mem_stride_x,
  output logic [AW-2:0]   mem_stride_y,
  output logic            mem_we,
  output logic [TILE-1:0] mem_dat_w,
  input  logic [TILE-1:0] mem_dat_r,
  input  logic            mem_stall
);
  localparam int CRW = $clog2(RD_DEPTH + 1);
  localparam logic [MEM_LAT-1:0] TAIL = MEM_LAT'(1) << (MEM_LAT - 1);
  seq_state_t state_q, state_d;
  logic we_q, done_q, done_d, out_vld_q, mem_we_q;
  logic [AW-1:0] addr_q, step_q, mem_addr_q;
  logic [AW-2:0] sx_q, sy_q, mem_sx_q, mem_sy_q;
  logic [CW-1:0] rem_q;
  logic [CRW-1:0] cred_q, cred_d;
  logic [MEM_LAT-1:0] pipe_q;
  logic [TILE-1:0] mem_dat_w_q;
  logic [$clog2(RD_DEPTH):0] fifo_cnt;
  logic accept, issue, push, pop, drained;
  always_comb begin
    cmd_ready = state_q == IDLE && !reset;
    accept = cmd_valid && cmd_ready;
    wr_ready = state_q == RUN && !mem_stall && we_q;
    issue = state_q == RUN && !mem_stall && (we_q ? wr_valid : cred_q != '0);
    push = pipe_q[MEM_LAT-1] && !mem_stall;
    rd_valid = fifo_cnt != '0;
    pop = rd_valid && rd_ready;
    // a presented store retires on this cycle's !mem_stall; loads must reach the pipeline tail
    drained = !mem_stall && !(out_vld_q && !we_q) && (pipe_q & ~TAIL) == '0;
    cred_d = cred_q - CRW'(issue && !we_q) + CRW'(pop);
    done_d = (accept && cmd_count == '0) || (state_q == DRAIN && drained);
    state_d = accept ? (cmd_count == '0 ? IDLE : RUN)
            : (issue && rem_q == CW'(1)) ? DRAIN
            : (state_q == DRAIN && drained) ? IDLE : state_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      done_q <= 1'b0;
      cred_q <= CRW'(RD_DEPTH);
      we_q <= 1'b0;
      addr_q <= '0;
      step_q <= '0;
      sx_q <= '0;
      sy_q <= '0;
      rem_q <= '0;
      out_vld_q <= 1'b0;
      pipe_q <= '0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_sx_q <= '0;
      mem_sy_q <= '0;
      mem_dat_w_q <= '0;
    end else begin
      state_q <= state_d;
      done_q <= done_d;
      cred_q <= cred_d;
      if (accept) begin
        we_q <= cmd_we;
        addr_q <= cmd_addr;
        step_q <= cmd_step;
        sx_q <= cmd_stride_x;
        sy_q <= cmd_stride_y;
        rem_q <= cmd_count;
      end
      if (issue) begin
        addr_q <= addr_q + step_q;
        rem_q <= rem_q - CW'(1);
      end
      // everything facing the dcache freezes while it stalls
      if (!mem_stall) begin
        out_vld_q <= issue;
        pipe_q <= MEM_LAT'({pipe_q, out_vld_q && !we_q});
        mem_we_q <= issue && we_q;
        if (issue) begin
          mem_addr_q <= addr_q;
          mem_sx_q <= sx_q;
          mem_sy_q <= sy_q;
          mem_dat_w_q <= we_q ? wr_data : '0;
        end
      end
    end
  dcache_tile_rd_fifo #(.W(TILE), .DEPTH(RD_DEPTH)) u_rd_fifo (
    .clk(clk),
    .rst(reset),
    .push_i(push),
    .dat_i(mem_dat_r),
    .pop_i(pop),
    .dat_o(rd_data),
    .count_o(fifo_cnt)
  );
  assign done = done_q;
  assign mem_addr = mem_addr_q;
  assign mem_stride_x = mem_sx_q;
  assign mem_stride_y = mem_sy_q;
  assign mem_we = mem_we_q;
  assign mem_dat_w = mem_dat_w_q;
`ifdef DCACHE_TILE_SEQ_PERF_EN
  logic [31:0] pstall_q, ptile_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pstall_q <= '0;
      ptile_q <= '0;
    end else begin
      if (state_q != IDLE && mem_stall && ~&pstall_q) pstall_q <= pstall_q + 32'd1;
      if (issue && ~&ptile_q) ptile_q <= ptile_q + 32'd1;
    end
  assign perf_stall_cycles = pstall_q;
  assign perf_tiles = ptile_q;
`endif
endmodule
